// File: rtl/timed_event_pkg.sv
// Shared types and default widths for the timed event player and the
// system timestamp counter it consumes.
package timed_event_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_TIME_WIDTH = 128;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/timed_event_player.sv
// Holds one (time, data) event and drives its payload onto a registered
// output with a one-cycle strobe once the system timestamp reaches it.
module timed_event_player
  import timed_event_pkg::*;
#(
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TIME_WIDTH-1:0] now,
  input  logic                  run,
  input  logic                  clear_late,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic [TIME_WIDTH-1:0] evt_time,
  input  logic [DATA_WIDTH-1:0] evt_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_strobe,
  output logic                  late,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  fired_count
);

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] t_hold_q;
  logic [DATA_WIDTH-1:0] d_hold_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  strobe_q;
  logic                  late_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic accept, fire, fire_late;

  assign accept    = evt_valid && evt_ready;
  // ">=" rather than "==" so an event whose time slipped by (pause,
  // back-to-back, already past) still fires instead of waiting a full wrap.
  assign fire      = (state_q == WAIT) && run && (now >= t_hold_q);
  assign fire_late = fire && (now != t_hold_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (fire)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_ready = (state_q == IDLE) && run;
    busy      = (state_q == WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_hold_q   <= '0;
      d_hold_q   <= '0;
      out_data_q <= '0;
      strobe_q   <= 1'b0;
      late_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      strobe_q <= fire;
      if (accept) begin
        t_hold_q <= evt_time;
        d_hold_q <= evt_data;
      end
      if (fire) begin
        out_data_q <= d_hold_q;
        cnt_q      <= cnt_q + CNT_WIDTH'(1);
      end
      // A late fire in the same cycle as a clear leaves the flag set.
      if (fire_late)       late_q <= 1'b1;
      else if (clear_late) late_q <= 1'b0;
    end
  end

  assign out_data    = out_data_q;
  assign out_strobe  = strobe_q;
  assign late        = late_q;
  assign fired_count = cnt_q;

endmodule

// File: tb/tb_timed_event_player.sv
// Scoreboard bench: stimulus pushes expected fires, a negedge monitor pops
// and compares whenever out_strobe is seen.
module tb_timed_event_player;

  localparam int TW = 128;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] now;
  logic          run;
  logic          clear_late;
  logic          evt_valid;
  logic          evt_ready;
  logic [TW-1:0] evt_time;
  logic [DW-1:0] evt_data;
  logic [DW-1:0] out_data;
  logic          out_strobe;
  logic          late;
  logic          busy;
  logic [CW-1:0] fired_count;

  timed_event_player #(.TIME_WIDTH(TW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .now(now), .run(run), .clear_late(clear_late),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
    .evt_data(evt_data), .out_data(out_data), .out_strobe(out_strobe),
    .late(late), .busy(busy), .fired_count(fired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          late;
    logic [CW-1:0] cnt;
    logic [TW-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (now=%0d)", name, act, exp, now);
    end
  endtask

  // now advances by one after every rising edge.
  task automatic tick();
    @(posedge clk);
    #1 now = now + 1;
  endtask

  task automatic tick_to(input int t);
    while (now < TW'(t)) tick();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l, input int c, input int t);
    exp_t e;
    e.data = d; e.late = l; e.cnt = CW'(c); e.t = TW'(t);
    exp_q.push_back(e);
  endtask

  // Present an event and wait (bounded) for the handshake edge.
  task automatic send(input int t, input logic [DW-1:0] d);
    int n = 0;
    evt_valid = 1'b1;
    evt_time  = TW'(t);
    evt_data  = d;
    while (!evt_ready && n < 300) begin
      tick();
      n++;
    end
    if (!evt_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: evt_ready stayed 0 for event time %0d", t);
    end else tick();
    evt_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got strobe with data 0x%0h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_time", now, e.t);
        chk("out_data", TW'(out_data), TW'(e.data));
        chk("late_at_fire", TW'(late), TW'(e.late));
        chk("fired_count", TW'(fired_count), TW'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1; now = '0; run = 1'b1; clear_late = 1'b0;
    evt_valid = 1'b0; evt_time = '0; evt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", TW'(out_data), 0);
    chk("rst_strobe", TW'(out_strobe), 0);
    chk("rst_late", TW'(late), 0);
    chk("rst_count", TW'(fired_count), 0);
    chk("rst_busy", TW'(busy), 0);
    reset = 1'b0;
    now   = '0;
    #1 chk("rst_ready", TW'(evt_ready), 1);

    // On-time event: fires on the edge sampling now==10, strobe seen at 11.
    tick_to(2);
    push(32'hA5A5_A5A5, 1'b0, 1, 11);
    send(10, 32'hA5A5_A5A5);
    tick_to(15);

    // Back-to-back: third event is one tick too close and fires late at 24.
    push(32'h1, 1'b0, 2, 21);
    push(32'h2, 1'b0, 3, 23);
    push(32'h3, 1'b1, 4, 25);
    send(20, 32'h1);
    send(22, 32'h2);
    send(23, 32'h3);
    tick_to(30);
    chk("late_after_b2b", TW'(late), 1);
    clear_late = 1'b1; tick(); clear_late = 1'b0;
    chk("late_cleared_1", TW'(late), 0);

    // Event already in the past at acceptance.
    tick_to(50);
    push(32'hBEEF, 1'b1, 5, 52);
    send(5, 32'hBEEF);
    tick_to(55);
    chk("late_past", TW'(late), 1);
    clear_late = 1'b1; tick(); clear_late = 1'b0;
    chk("late_cleared_2", TW'(late), 0);

    // Clear and late fire in the same cycle: set wins.
    tick_to(60);
    push(32'h66, 1'b1, 6, 62);
    send(6, 32'h66);
    clear_late = 1'b1; tick(); clear_late = 1'b0;
    chk("late_set_wins", TW'(late), 1);
    clear_late = 1'b1; tick(); clear_late = 1'b0;

    // Pause across the event time; fires late once run returns at 120.
    tick_to(80);
    send(100, 32'h100);
    tick_to(90);
    run = 1'b0;
    #1 chk("pause_ready", TW'(evt_ready), 0);
    while (now < 120) begin
      tick();
      if (now == 105) begin
        chk("pause_ready_mid", TW'(evt_ready), 0);
        chk("pause_busy_mid", TW'(busy), 1);
      end
    end
    push(32'h100, 1'b1, 7, 121);
    run = 1'b1;
    tick_to(125);

    // Reset while holding an event: it never fires.
    clear_late = 1'b1; tick(); clear_late = 1'b0;
    tick_to(130);
    send(200, 32'h200);
    tick_to(150);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_out_data", TW'(out_data), 0);
    chk("mid_rst_late", TW'(late), 0);
    chk("mid_rst_count", TW'(fired_count), 0);
    chk("mid_rst_busy", TW'(busy), 0);
    chk("mid_rst_ready", TW'(evt_ready), 1);
    tick_to(210);

    // Counter wrap: 16 on-time events take the 4-bit count back to 0.
    for (int i = 0; i < 16; i++) begin
      int n;
      n = int'(now);
      push(DW'(i + 32'h50), 1'b0, (i + 1) % 16, n + 3);
      send(n + 2, DW'(i + 32'h50));
      tick(); tick();
    end
    tick(); tick();
    chk("wrap_count", TW'(fired_count), 0);
    chk("wrap_late", TW'(late), 0);
    chk("wrap_out_data", TW'(out_data), TW'(32'h5F));
    repeat (4) tick();
    chk("hold_out_data", TW'(out_data), TW'(32'h5F));
    chk("pending_expected", TW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
